uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter DI_WIDTH SHALL default to 8 and set the data width.
REQ-003 Parameter DEPTH_LOG2 SHALL default to 4 and set the FIFO depth to 2^DEPTH_LOG2 entries.
REQ-004 clk  input  1  system clock, same clock as the receiver.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 din  input  DI_WIDTH  received byte from the receiver data output.
REQ-007 din_vld  input  1  receiver valid level, may stay high for many clk cycles per byte.
REQ-008 err_in  input  1  receiver parity error level.
REQ-009 dout  output  DI_WIDTH  head-of-FIFO data (first-word fall-through).
REQ-010 dout_vld  output  1  head entry valid.
REQ-011 dout_rdy  input  1  consumer accepts the head entry.
REQ-012 level  output  DEPTH_LOG2+1  current occupancy.
REQ-013 full, empty  output  1 each  occupancy flags.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-016 Write strobe SHALL be din_vld & ~din_vld_d, where din_vld_d is din_vld registered; exactly one write per din_vld rising edge regardless of how long din_vld stays high.
REQ-017 On a write strobe with full=0, din SHALL be stored at wr_ptr, and wr_ptr SHALL increment modulo 2^DEPTH_LOG2.
REQ-018 Pop SHALL occur when dout_vld & dout_rdy; rd_ptr SHALL then increment modulo 2^DEPTH_LOG2.
REQ-019 dout SHALL equal mem[rd_ptr] combinationally; dout_vld SHALL equal ~empty.
REQ-020 Latency: for a write strobe sampled at edge N into an empty FIFO, dout_vld SHALL be 1 and dout SHALL equal din starting in the cycle after edge N.
REQ-021 level SHALL be +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop; full = (level == 2^DEPTH_LOG2); empty = (level == 0).
REQ-022 A write strobe while full with a simultaneous pop SHALL be accepted, and level SHALL stay at full.
REQ-023 A write strobe while full without a pop SHALL be dropped, leave FIFO contents unchanged, and set ovf at the next edge.
REQ-024 A pop while empty is impossible (dout_vld=0) and SHALL change nothing.
REQ-025 ovf SHALL stay set until ovf_clr=1; if ovf_clr and a new overflow occur in the same cycle, set SHALL win.

Reset
REQ-026 While rst=0: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, dout_vld=0, ovf=0.
REQ-027 While rst=0, din_vld_d SHALL reset to 1 so that din_vld already high at reset release produces no write.
REQ-028 Storage array contents SHALL NOT be reset; dout is don't-care while dout_vld=0.
REQ-029 Asserting rst mid-operation SHALL discard all stored entries immediately.

Configuration
REQ-030 With macro UART_RX_FIFO_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits) and input err_clr (1 bit).
REQ-031 With UART_RX_FIFO_ERR_CNT_EN defined, err_cnt SHALL count rising edges of err_in, saturate at 255, clear synchronously on err_clr (an increment in the same cycle loses), and reset to 0 on rst; err_in edge detection SHALL reset to 1.
REQ-032 Without UART_RX_FIFO_ERR_CNT_EN, err_cnt, err_clr and the counter logic SHALL be absent, and err_in SHALL be unused.

Verification
REQ-033 Hold din_vld high for 500 cycles with din=0xA5 -> exactly one entry; level=1; dout=0xA5; dout_vld=1 one cycle after the rise.
REQ-034 Push 16 bytes 0x00..0x0F with dout_rdy=0 -> full=1, level=16; a 17th push -> ovf=1 and contents unchanged; drain -> 0x00..0x0F in order, then empty=1.
REQ-035 With the FIFO full, push 0x55 in the same cycle as a pop -> no ovf; level stays 16; 0x55 is read out last.
REQ-036 Hold din_vld=1 during reset release -> no write, empty=1; pulse rst low with 5 entries stored -> level=0, dout_vld=0 immediately.
REQ-037 Set ovf, then assert ovf_clr and a new overflow in the same cycle -> ovf remains 1; a later ovf_clr alone -> ovf=0.
REQ-038 With UART_RX_FIFO_ERR_CNT_EN defined, give 300 err_in pulses -> err_cnt=255; assert err_clr -> err_cnt=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-detected writes, first-word fall-through read, sticky overflow.
// Optional parity-error counter is enabled with `define UART_RX_FIFO_ERR_CNT_EN.
module uart_rx_fifo #(
    parameter int unsigned DI_WIDTH   = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DI_WIDTH-1:0]   din,
    input  logic                  din_vld,
    input  logic                  err_in,
    output logic [DI_WIDTH-1:0]   dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf,
`ifdef UART_RX_FIFO_ERR_CNT_EN
    output logic [7:0]            err_cnt,
    input  logic                  err_clr,
`endif
    input  logic                  ovf_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DI_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  din_vld_d;
    logic                  wr_stb;
    logic                  wr_en;
    logic                  pop;

    assign wr_stb   = din_vld & ~din_vld_d;
    assign pop      = dout_vld & dout_rdy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en    = wr_stb & (~full | pop);
    assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (level == '0);
    assign dout_vld = ~empty;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_vld_d <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf       <= 1'b0;
        end else begin
            din_vld_d <= din_vld;
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
            if (wr_stb && full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_ERR_CNT_EN
    logic err_in_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_in_d <= 1'b1;
            err_cnt  <= '0;
        end else begin
            err_in_d <= err_in;
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_in && !err_in_d && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_err_in;
    assign unused_err_in = err_in;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour plus hand sequences
// for fill/overflow/drain, full write-with-pop, reset handling and the optional error counter.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;
    logic       err_in = 1'b0;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy = 1'b0;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DI_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .err_in   (err_in),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
`ifdef UART_RX_FIFO_ERR_CNT_EN
        .err_cnt  (err_cnt),
        .err_clr  (err_clr),
`endif
        .ovf_clr  (ovf_clr)
    );

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic       rdy;
        logic [4:0] lvl;
        logic       dv;
        logic [7:0] dout;
        logic       chk_dout;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic rdy, input logic clr);
        @(negedge clk);
        din = b;
        din_vld = 1'b1;
        dout_rdy = rdy;
        ovf_clr = clr;
        @(negedge clk);
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk({name, "_vld"}, 32'(dout_vld), 32'd1);
        chk(name, 32'(dout), 32'(exp));
        dout_rdy = 1'b1;
        @(negedge clk);
        dout_rdy = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) push(base + 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 din    vld   rdy   lvl   dv    dout  chk
        vecs[0]  = '{8'h11, 1'b1, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1};
        vecs[1]  = '{8'h22, 1'b1, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1};
        vecs[2]  = '{8'h22, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1};
        vecs[3]  = '{8'h22, 1'b1, 1'b0, 5'd2, 1'b1, 8'h11, 1'b1};
        vecs[4]  = '{8'h00, 1'b0, 1'b1, 5'd1, 1'b1, 8'h22, 1'b1};
        vecs[5]  = '{8'h33, 1'b1, 1'b1, 5'd1, 1'b1, 8'h33, 1'b1};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{8'h44, 1'b1, 1'b1, 5'd1, 1'b1, 8'h44, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h44, 1'b1};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout_vld", 32'(dout_vld), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            din = vecs[i].din;
            din_vld = vecs[i].vld;
            dout_rdy = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_dout_vld", i), 32'(dout_vld), 32'(vecs[i].dv));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].lvl == 5'd0));
            if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
        end
        @(negedge clk);
        din_vld = 1'b0;
        dout_rdy = 1'b0;

        // Long valid level produces exactly one entry
        @(negedge clk);
        din = 8'hA5;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_first_vld", 32'(dout_vld), 32'd1);
        chk("hold_first_dout", 32'(dout), 32'hA5);
        repeat (499) @(posedge clk);
        #1;
        chk("hold_level", 32'(level), 32'd1);
        chk("hold_dout", 32'(dout), 32'hA5);
        @(negedge clk);
        din_vld = 1'b0;
        pop_check("hold_pop", 8'hA5);
        chk("hold_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain in order
        fill(8'h00);
        push(8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i));
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", 32'(ovf), 32'd0);

        // Write into a full FIFO in the same cycle as a pop
        fill(8'h80);
        push(8'h55, 1'b1, 1'b0);
        chk("fullpop_ovf", 32'(ovf), 32'd0);
        chk("fullpop_level", 32'(level), 32'd16);
        for (int i = 1; i < 16; i++) pop_check($sformatf("fp_drain%0d", i), 8'h80 + 8'(i));
        pop_check("fp_last", 8'h55);
        chk("fp_empty", 32'(empty), 32'd1);

        // Overflow set wins against a simultaneous clear
        fill(8'h20);
        push(8'hE1, 1'b0, 1'b0);
        chk("ovf2_set", 32'(ovf), 32'd1);
        push(8'hE2, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr_later", 32'(ovf), 32'd0);
        pop_check("ovf2_head", 8'h20);

        // Valid held high across reset release: no write
        @(negedge clk);
        rst = 1'b0;
        din = 8'h77;
        din_vld = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("relvld_empty", 32'(empty), 32'd1);
        chk("relvld_level", 32'(level), 32'd0);
        @(negedge clk);
        din_vld = 1'b0;

        // Mid-operation reset discards entries immediately
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_dout_vld", 32'(dout_vld), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_level", 32'(level), 32'd0);

`ifdef UART_RX_FIFO_ERR_CNT_EN
        chk("errcnt_rst", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            err_in = 1'b1;
            @(negedge clk);
            err_in = 1'b0;
        end
        chk("errcnt_sat", 32'(err_cnt), 32'd255);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errcnt_clr", 32'(err_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
